// File: rtl/seq_lut_pkg.sv
// Shared definitions for the sequencer LUT loader and sequencer benches.
// Contents: entry width and field offsets, sequencer state encodings, loader
// FSM states, loader error codes, CRC-32 constants and a one-word CRC step.
package seq_lut_pkg;

  // Entry layout: {state[28:26], repeat[25:18], data_len[17:2], eof[1], sof[0]}
  localparam int unsigned LutDW    = 29;
  localparam int unsigned SofBit   = 0;
  localparam int unsigned EofBit   = 1;
  localparam int unsigned LenLsb   = 2;
  localparam int unsigned LenMsb   = 17;
  localparam int unsigned RepLsb   = 18;
  localparam int unsigned RepMsb   = 25;
  localparam int unsigned StateLsb = 26;
  localparam int unsigned StateMsb = 28;

  // Sequencer state encodings carried in the entry state field.
  typedef enum logic [2:0] {
    SeqRst     = 3'd0,
    SeqIdle    = 3'd1,
    SeqArm     = 3'd2,
    SeqRun     = 3'd3,
    SeqRepeat  = 3'd4,
    SeqWait    = 3'd5,
    SeqHalt    = 3'd6,
    SeqReadout = 3'd7
  } seq_state_e;

  typedef enum logic [2:0] {
    ErrNone     = 3'd0,
    ErrFirstSof = 3'd1,
    ErrEof      = 3'd2,
    ErrState    = 3'd3,
    ErrOverflow = 3'd4,
    ErrVerify   = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StClrW,
    StWrite,
    StClrR,
    StVerify,
    StCheck,
    StRun,
    StError
  } loader_state_e;

  localparam logic [31:0] CrcPoly = 32'h04C1_1DB7;
  localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;

  // MSB-first, non-reflected CRC-32 over one 32-bit word, no final XOR.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = (c << 1) ^ CrcPoly;
      else                 c = c << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/seq_lut_crc32.sv
// Running CRC-32 accumulator, one 32-bit word per enabled cycle.
// Ports:
//   clk      clock
//   reset_ni async active-low reset (CRC register -> 0)
//   clr_i    load the CRC initial value (has priority over en_i)
//   en_i     fold data_i into the running CRC
//   data_i   32-bit word
//   crc_o    current CRC value
module seq_lut_crc32
  import seq_lut_pkg::*;
(
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);

  logic [31:0] r_crc;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_crc <= '0;
    end else if (clr_i) begin
      r_crc <= CrcInit;
    end else if (en_i) begin
      r_crc <= crc32_step(r_crc, data_i);
    end
  end

  assign crc_o = r_crc;

endmodule

// File: rtl/sequencer_lut_loader.sv
// Host-side programmer for the sequencer LUT configuration port.
// Holds the sequencer in reset, streams entries into the LUT through the
// auto-incrementing write port, format-checks every entry, reads the table
// back and releases the sequencer only when write and read CRCs agree.
// Ports:
//   clk, reset_ni                      clock, async active-low reset
//   start_i                            begin a load session (IDLE/RUN/ERROR only)
//   entry_valid_i/entry_ready_o        host entry handshake
//   entry_data_i/entry_last_i          entry payload and end-of-table marker
//   busy_o, done_o                     session active, 1-cycle verified pulse
//   error_o, error_code_o              sticky error and its cause
//   entry_count_o                      entries written this session
//   seq_reset_o, seq_addr_clr_o        sequencer reset and LUT address clear
//   lut_wen_o, lut_write_data_o        LUT write strobe and data
//   lut_rden_o, lut_read_data_i        LUT read strobe and combinational data
module sequencer_lut_loader
  import seq_lut_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DW    = LutDW,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_ni,
  input  logic          start_i,
  input  logic          entry_valid_i,
  output logic          entry_ready_o,
  input  logic [DW-1:0] entry_data_i,
  input  logic          entry_last_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [2:0]    error_code_o,
  output logic [CW-1:0] entry_count_o,
  output logic          seq_reset_o,
  output logic          seq_addr_clr_o,
  output logic          lut_wen_o,
  output logic [DW-1:0] lut_write_data_o,
  output logic          lut_rden_o,
  input  logic [DW-1:0] lut_read_data_i
);

  loader_state_e r_state;
  logic          r_seq_reset;
  logic          r_addr_clr;
  logic          r_wen;
  logic          r_rden;
  logic          r_done;
  logic          r_error;
  err_code_e     r_err_code;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_rd_left;
  logic          r_last;  // last entry accepted; its wen is in flight

  logic          w_start;
  logic          w_hs;
  logic          w_full;
  err_code_e     w_fmt_err;
  logic [31:0]   w_wr_crc;
  logic [31:0]   w_rd_crc;

  assign w_start = start_i &&
                   (r_state == StIdle || r_state == StRun || r_state == StError);
  assign w_full  = (r_count == CW'(DEPTH));

  assign entry_ready_o = (r_state == StWrite) && !r_last && !w_full;
  assign w_hs          = entry_valid_i && entry_ready_o;

  // First failing rule wins.
  always_comb begin
    w_fmt_err = ErrNone;
    if (r_count == '0 && !entry_data_i[SofBit]) begin
      w_fmt_err = ErrFirstSof;
    end else if (entry_data_i[EofBit] != entry_last_i) begin
      w_fmt_err = ErrEof;
    end else if (entry_data_i[StateMsb:StateLsb] == '0) begin
      w_fmt_err = ErrState;
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= StIdle;
      r_seq_reset <= 1'b1;
      r_addr_clr  <= 1'b0;
      r_wen       <= 1'b0;
      r_rden      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= ErrNone;
      r_wdata     <= '0;
      r_count     <= '0;
      r_rd_left   <= '0;
      r_last      <= 1'b0;
    end else begin
      r_addr_clr <= 1'b0;
      r_wen      <= 1'b0;
      r_done     <= 1'b0;
      unique case (r_state)
        StIdle, StRun, StError: begin
          if (w_start) begin
            r_state     <= StClrW;
            r_seq_reset <= 1'b1;
            r_addr_clr  <= 1'b1;
            r_error     <= 1'b0;
            r_err_code  <= ErrNone;
            r_count     <= '0;
            r_last      <= 1'b0;
          end
        end
        StClrW: begin
          r_state <= StWrite;
        end
        StWrite: begin
          if (r_last) begin
            // Wen of the final entry is on the port this cycle.
            r_state    <= StClrR;
            r_addr_clr <= 1'b1;
            r_last     <= 1'b0;
          end else if (w_hs) begin
            if (w_fmt_err != ErrNone) begin
              r_state    <= StError;
              r_error    <= 1'b1;
              r_err_code <= w_fmt_err;
            end else begin
              r_wen   <= 1'b1;
              r_wdata <= entry_data_i;
              r_count <= r_count + CW'(1);
              r_last  <= entry_last_i;
            end
          end else if (entry_valid_i && w_full) begin
            // Table full and the host still offers entries without a last.
            r_state    <= StError;
            r_error    <= 1'b1;
            r_err_code <= ErrOverflow;
          end
        end
        StClrR: begin
          r_state   <= StVerify;
          r_rden    <= 1'b1;
          r_rd_left <= r_count;
        end
        StVerify: begin
          r_rd_left <= r_rd_left - CW'(1);
          if (r_rd_left == CW'(1)) begin
            r_rden  <= 1'b0;
            r_state <= StCheck;
          end
        end
        StCheck: begin
          if (w_wr_crc == w_rd_crc) begin
            r_state     <= StRun;
            r_done      <= 1'b1;
            r_seq_reset <= 1'b0;
          end else begin
            r_state    <= StError;
            r_error    <= 1'b1;
            r_err_code <= ErrVerify;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  seq_lut_crc32 u_wr_crc (
    .clk     (clk),
    .reset_ni(reset_ni),
    .clr_i   (w_start),
    .en_i    (r_wen),
    .data_i  (32'(r_wdata)),
    .crc_o   (w_wr_crc)
  );

  // Read data is sampled in the rden cycle, before the sequencer increments.
  seq_lut_crc32 u_rd_crc (
    .clk     (clk),
    .reset_ni(reset_ni),
    .clr_i   (w_start),
    .en_i    (r_rden),
    .data_i  (32'(lut_read_data_i)),
    .crc_o   (w_rd_crc)
  );

  assign busy_o           = !(r_state == StIdle || r_state == StRun || r_state == StError);
  assign done_o           = r_done;
  assign error_o          = r_error;
  assign error_code_o     = r_err_code;
  assign entry_count_o    = r_count;
  assign seq_reset_o      = r_seq_reset;
  assign seq_addr_clr_o   = r_addr_clr;
  assign lut_wen_o        = r_wen;
  assign lut_write_data_o = r_wdata;
  assign lut_rden_o       = r_rden;

endmodule
